// File: rtl/tpu_pkg.sv
// Shared fixed-point types and constants for the TPU datapath.
package tpu_pkg;
  typedef logic signed [15:0] fixed_t;

  localparam int     FRAC_BITS_DEFAULT = 8;
  localparam fixed_t FIXED_MAX = 16'sh7FFF;
  localparam fixed_t FIXED_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } wu_state_t;
endpackage

// File: rtl/fxp_sub_sat.sv
// Combinational a - b with saturation to the Q8.8 range.
module fxp_sub_sat
  import tpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output fixed_t              y
);

  localparam logic signed [W:0] HI = (W+1)'(FIXED_MAX);
  localparam logic signed [W:0] LO = (W+1)'(FIXED_MIN);

  // One extra bit so the difference itself never wraps.
  logic signed [W:0] diff;

  assign diff = (W+1)'(a) - (W+1)'(b);

  always_comb begin
    if (diff > HI) begin
      y = FIXED_MAX;
    end else if (diff < LO) begin
      y = FIXED_MIN;
    end else begin
      y = fixed_t'(diff[15:0]);
    end
  end

endmodule

// File: rtl/weight_update.sv
// SGD weight update: w - ((g * lr) >>> FRAC_BITS), saturated,
// three-register pipeline with a pass FSM.
module weight_update
  import tpu_pkg::*;
#(
  parameter int N_WEIGHTS = 4,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] lr_in,
  input  logic        weight_valid_in,
  input  fixed_t      weight_in,
  input  logic        grad_valid_in,
  input  fixed_t      grad_in,
  output logic        update_valid_out,
  output fixed_t      update_data_out,
  output logic        busy,
  output logic        done,
  output logic        pair_err
);

  wu_state_t state;
  wu_state_t state_nxt;

  logic [7:0]  cnt;
  logic [15:0] lr_q;

  logic        start_ok;
  logic        accept;
  logic        one_sided;
  logic        last;
  logic        pipe_empty;

  logic signed [31:0] g_ext;
  logic signed [31:0] lr_ext;
  logic signed [31:0] prod;

  logic               v1;
  fixed_t             w1;
  logic signed [31:0] p1;
  logic signed [31:0] w1_ext;
  logic               v2;
  fixed_t             r2;
  fixed_t             sat;

  assign start_ok  = (state == IDLE) && start;
  assign accept    = (state == RUN) && weight_valid_in && grad_valid_in;
  assign one_sided = (state == RUN) && (weight_valid_in ^ grad_valid_in);
  assign last      = accept && (cnt == 8'(N_WEIGHTS - 1));

  // Pass ends once the final result has left the output register.
  assign pipe_empty = !v1 && !v2 && update_valid_out;

  assign g_ext  = 32'(grad_in);
  assign lr_ext = {16'd0, lr_q};
  assign prod   = g_ext * lr_ext;
  assign w1_ext = 32'(w1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (last) state_nxt = DRAIN;
      DRAIN: if (pipe_empty) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lr_q     <= '0;
      cnt      <= '0;
      pair_err <= 1'b0;
    end else if (start_ok) begin
      lr_q     <= lr_in;
      cnt      <= '0;
      pair_err <= 1'b0;
    end else begin
      if (accept) cnt <= cnt + 8'd1;
      if (one_sided) pair_err <= 1'b1;
    end
  end

  fxp_sub_sat #(
    .W(32)
  ) u_sub (
    .a(w1_ext),
    .b(p1),
    .y(sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1               <= 1'b0;
      w1               <= '0;
      p1               <= '0;
      v2               <= 1'b0;
      r2               <= '0;
      update_valid_out <= 1'b0;
      update_data_out  <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        w1 <= weight_in;
        p1 <= prod >>> FRAC_BITS;
      end
      v2 <= v1;
      if (v1) r2 <= sat;
      update_valid_out <= v2;
      if (v2) update_data_out <= r2;
    end
  end

endmodule

// File: tb/tb_weight_update.sv
// Randomized bench for weight_update against a queue-based
// reference model of the pass/pair rules.
module tb_weight_update;

  localparam int N   = 4;
  localparam int BIG = 1 << 30;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] lr_in;
  logic        weight_valid_in;
  logic [15:0] weight_in;
  logic        grad_valid_in;
  logic [15:0] grad_in;
  logic        update_valid_out;
  logic [15:0] update_data_out;
  logic        busy;
  logic        done;
  logic        pair_err;

  weight_update #(
    .N_WEIGHTS(N),
    .FRAC_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .lr_in(lr_in),
    .weight_valid_in(weight_valid_in),
    .weight_in(weight_in),
    .grad_valid_in(grad_valid_in),
    .grad_in(grad_in),
    .update_valid_out(update_valid_out),
    .update_data_out(update_data_out),
    .busy(busy),
    .done(done),
    .pair_err(pair_err)
  );

  typedef struct {
    logic [15:0] d;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  bit          mon_en = 0;
  bit          active = 0;
  bit          mrun = 0;
  int          mcnt = 0;
  logic [15:0] mlr = '0;
  bit          perr_cur = 0;
  bit          perr_nxt = 0;
  int          nxt_cyc = 0;
  int          busy_from = BIG;
  int          busy_end = BIG;
  int          done_cyc = BIG;
  int          rst_eff = BIG;
  logic [15:0] last = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, want, cyc);
    end
  endtask

  // new = sat(w - floor(g * lr / 256))
  function automatic logic [15:0] ref_upd(logic [15:0] w,
                                          logic [15:0] g,
                                          logic [15:0] lr);
    longint p;
    longint f;
    longint r;
    p = longint'($signed(g)) * longint'(lr);
    f = p / 256;
    if (p < 0 && (p % 256) != 0) f = f - 1;
    r = longint'($signed(w)) - f;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  function automatic logic [15:0] rnd_fx();
    case ($urandom % 8)
      0: return 16'h7FFF;
      1: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Drive one cycle; the model decides what the next edge does.
  task automatic drive(bit r, bit s, logic [15:0] lr,
                       bit wv, logic [15:0] w,
                       bit gv, logic [15:0] g, int xp);
    int p;
    p = cyc;
    rst = r;
    start = s;
    lr_in = lr;
    weight_valid_in = wv;
    weight_in = w;
    grad_valid_in = gv;
    grad_in = g;
    perr_cur = perr_nxt;
    if (r) begin
      while (q.size() > 0 && q[$].due > p) void'(q.pop_back());
      active = 0;
      mrun = 0;
      if (busy_end > p + 1) busy_end = p + 1;
      if (done_cyc > p) done_cyc = BIG;
      perr_nxt = 0;
      rst_eff = p + 1;
    end else if (s && (!active || p > done_cyc)) begin
      active = 1;
      mrun = 1;
      mcnt = 0;
      mlr = lr;
      perr_nxt = 0;
      busy_from = p + 1;
      busy_end = BIG;
      done_cyc = BIG;
    end else if (mrun) begin
      if (wv && gv) begin
        q.push_back('{(xp >= 0) ? xp[15:0] : ref_upd(w, g, mlr), p + 3});
        mcnt++;
        if (mcnt == N) begin
          mrun = 0;
          done_cyc = p + 4;
          busy_end = p + 4;
        end
      end else if (wv ^ gv) begin
        perr_nxt = 1;
      end
    end
    nxt_cyc = p + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  task automatic pair(logic [15:0] w, logic [15:0] g, int xp);
    drive(0, 0, 0, 1, w, 1, g, xp);
  endtask

  task automatic begin_pass(logic [15:0] lr);
    drive(0, 1, lr, 0, 0, 0, 0, -1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && (mrun || cyc <= done_cyc); i++)
      drive(0, 0, 0, $urandom % 2 == 0, 16'($urandom),
            $urandom % 2 == 0, 16'($urandom), -1);
    if (mrun || cyc <= done_cyc) chk("pass_timeout", 0, 1);
  endtask

  task automatic rand_pass();
    begin_pass(16'($urandom));
    for (int i = 0; i < 200 && (mrun || cyc <= done_cyc); i++)
      drive(0, $urandom % 8 == 0, 16'($urandom),
            $urandom % 4 != 0, rnd_fx(),
            $urandom % 4 != 0, rnd_fx(), -1);
    if (mrun || cyc <= done_cyc) chk("pass_timeout", 0, 1);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, 32'(update_valid_out), 0);
    chk({tag, "_data"}, 32'(update_data_out), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_perr"}, 32'(pair_err), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == rst_eff) last = '0;
      if (update_valid_out) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 1, 0);
        end else begin
          e = q.pop_front();
          chk("data", 32'(update_data_out), 32'(e.d));
          chk("latency", cyc, e.due);
        end
        last = update_data_out;
      end else begin
        chk("hold", 32'(update_data_out), 32'(last));
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("missing_valid", 0, 1);
          void'(q.pop_front());
        end
      end
      chk("done", 32'(done), 32'(cyc == done_cyc));
      chk("busy", 32'(busy), 32'(cyc >= busy_from && cyc < busy_end));
      chk("pair_err", 32'(pair_err),
          32'((cyc >= nxt_cyc) ? perr_nxt : perr_cur));
    end
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    lr_in = '0;
    weight_valid_in = 1'b0;
    weight_in = '0;
    grad_valid_in = 1'b0;
    grad_in = '0;

    drive(1, 0, 0, 0, 0, 0, 0, -1);
    drive(1, 1, 16'h1234, 1, 16'h1111, 1, 16'h2222, -1);
    mon_en = 1;
    chk_zero("reset");

    // Known values, 1-cycle gaps between pairs.
    begin_pass(16'h0080);
    pair(16'h0100, 16'h0200, 16'h0000);
    idle(1);
    pair(16'h0000, 16'hFFFF, 16'h0001);
    idle(1);
    pair(16'h0300, 16'h0100, -1);
    idle(1);
    pair(16'hFF00, 16'h0400, -1);
    wait_done();
    idle(2);

    // Saturation, back-to-back, start ignored mid-pass.
    begin_pass(16'h0100);
    pair(16'h7F00, 16'h8000, 16'h7FFF);
    pair(16'h8100, 16'h7F00, 16'h8000);
    drive(0, 1, 16'hFFFF, 1, 16'h0040, 1, 16'h0123, -1);
    pair(16'h1234, 16'hF00D, -1);
    wait_done();

    // One-sided valids set pair_err without consuming a slot.
    begin_pass(16'h0080);
    drive(0, 0, 0, 1, 16'h0100, 0, 16'h0200, -1);
    chk("perr_set", 32'(pair_err), 1);
    drive(0, 0, 0, 0, 16'h0100, 1, 16'h0200, -1);
    for (int i = 0; i < N; i++) pair(rnd_fx(), rnd_fx(), -1);
    wait_done();
    chk("perr_sticky", 32'(pair_err), 1);
    begin_pass(16'h0040);
    chk("perr_clear", 32'(pair_err), 0);
    for (int i = 0; i < N; i++) pair(rnd_fx(), rnd_fx(), -1);
    wait_done();

    // Reset one cycle after the second acceptance.
    begin_pass(16'h0200);
    pair(16'h0100, 16'h0010, -1);
    pair(16'h0200, 16'h0020, -1);
    drive(1, 0, 0, 1, 16'h0300, 1, 16'h0030, -1);
    chk_zero("rst_mid");
    idle(6);
    chk_zero("rst_after");

    for (int k = 0; k < 25; k++) begin
      rand_pass();
      idle($urandom % 3);
    end

    idle(5);
    chk("queue_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
